// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
//   FWD_*      : EX operand select encodings (register file / WB / MEM)
//   hz_state_e : stall FSM state encoding
//   HZ_CNT_W   : width of the stall-length counter
//   cnt_max    : larger of two stall-length requests
package hazard_pkg;

    localparam int unsigned HZ_CNT_W = 3;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_e;

    typedef logic [HZ_CNT_W-1:0] hz_cnt_t;

    function automatic hz_cnt_t cnt_max(input hz_cnt_t a, input hz_cnt_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_fwd_sel.sv
// Per-operand forwarding priority comparator (module fwd_sel).
//   src            : EX source register
//   mem_wr, mem_we : MEM destination / write enable (highest priority)
//   wb_wr,  wb_we  : WB destination / write enable
//   sel            : FWD_MEM, FWD_WB or FWD_RF; register 0 is never forwarded
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] mem_wr,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] wb_wr,
    input  logic              wb_we,
    output logic [1:0]        sel
);

    // MEM holds the younger result, so it wins over WB on the same register.
    always_comb begin
        sel = FWD_RF;
        if (src != '0) begin
            if (mem_we && (mem_wr == src)) begin
                sel = FWD_MEM;
            end else if (wb_we && (wb_wr == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Detects load-use and ID-stage branch operand hazards, stretches stalls for
// multi-cycle load latency, and produces forwarding selects for EX.
//   clk, rst (sync, active-low)
//   id_*  : ID-stage instruction sources / branch info
//   ex_*  : EX sources, destination, write/load flags
//   mem_*, wb_* : later-stage destinations and write enables
//   fwd_a, fwd_b : EX operand selects (combinational)
//   pc_write, ifid_write, idex_bubble, ifid_flush, busy : pipeline control
// Optional: define PIPE_HAZARD_PERF_EN to add saturating stall_cnt/flush_cnt.
module pipe_hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned BR_IN_ID = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_is_branch,
    input  logic              id_br_taken,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_wr,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_wr,
    input  logic [REG_AW-1:0] wb_wr,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              busy
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam hz_cnt_t LAT    = HZ_CNT_W'(LOAD_LAT);
    localparam hz_cnt_t LAT_M1 = HZ_CNT_W'(LOAD_LAT - 1);

    hz_state_e state_q, state_d;
    hz_cnt_t   cnt_q, cnt_d, cnt_req;
    logic      mem_load_q;
    logic      br_en, lu_hz, br_ex_hz, br_mem_hz, hazard;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    // Does register r feed the ID instruction?
    function automatic logic hit(input logic [REG_AW-1:0] r,
                                 input logic [REG_AW-1:0] rs,
                                 input logic [REG_AW-1:0] rt,
                                 input logic              uses_rt);
        return (r != '0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .src(ex_rs), .mem_wr(mem_wr), .mem_we(mem_reg_write),
        .wb_wr(wb_wr), .wb_we(wb_reg_write), .sel(fwd_a_raw)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .src(ex_rt), .mem_wr(mem_wr), .mem_we(mem_reg_write),
        .wb_wr(wb_wr), .wb_we(wb_reg_write), .sel(fwd_b_raw)
    );

    assign fwd_a = rst ? fwd_a_raw : FWD_RF;
    assign fwd_b = rst ? fwd_b_raw : FWD_RF;

    // Hazard classification and the longest stall any of them requires.
    always_comb begin
        br_en     = (BR_IN_ID != 0) && id_is_branch;
        lu_hz     = ex_mem_read && hit(ex_wr, id_rs, id_rt, id_uses_rt);
        br_ex_hz  = br_en && ex_reg_write && hit(ex_wr, id_rs, id_rt, id_uses_rt);
        br_mem_hz = br_en && mem_reg_write && mem_load_q
                    && hit(mem_wr, id_rs, id_rt, id_uses_rt);
        hazard    = lu_hz || br_ex_hz || br_mem_hz;
        cnt_req   = '0;
        if (lu_hz) begin
            cnt_req = LAT_M1;
        end
        if (br_mem_hz) begin
            cnt_req = cnt_max(cnt_req, LAT_M1);
        end
        if (br_ex_hz) begin
            cnt_req = cnt_max(cnt_req, ex_mem_read ? LAT : '0);
        end
    end

    // State, stall counter and MEM-stage load tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= HZ_RUN;
            cnt_q      <= '0;
            mem_load_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_load_q <= ex_mem_read;
        end
    end

    // Next state and pipeline control; reset forces the stalled/idle pattern.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        busy        = 1'b0;
        case (state_q)
            HZ_RUN: begin
                if (hazard) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_req;
                    if (cnt_req != '0) begin
                        state_d = HZ_STALL;
                    end
                end else begin
                    ifid_flush = id_br_taken;
                end
            end
            HZ_STALL: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                busy        = 1'b1;
                cnt_d       = cnt_q - 1'b1;
                if (cnt_q <= hz_cnt_t'(1)) begin
                    state_d = HZ_RUN;
                end
            end
            default: begin
                state_d = HZ_RUN;
                cnt_d   = '0;
            end
        endcase
        if (!rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b0;
            busy        = 1'b0;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    // Saturating event counters for stall cycles and flushes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (ifid_flush && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: three instances share one stimulus
// stream (LOAD_LAT=1, LOAD_LAT=3, and LOAD_LAT=1 with BR_IN_ID=0).
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr, mem_wr, wb_wr;
    logic       id_uses_rt, id_is_branch, id_br_taken;
    logic       ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;

    logic [1:0] a1_fa, a1_fb, a3_fa, a3_fb, an_fa, an_fb;
    logic       a1_pc, a1_iw, a1_bub, a1_fl, a1_busy;
    logic       a3_pc, a3_iw, a3_bub, a3_fl, a3_busy;
    logic       an_pc, an_iw, an_bub, an_fl, an_busy;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .BR_IN_ID(1)) u1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
        .id_br_taken(id_br_taken), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_wr(ex_wr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_wr(mem_wr), .wb_wr(wb_wr), .mem_reg_write(mem_reg_write),
        .wb_reg_write(wb_reg_write), .fwd_a(a1_fa), .fwd_b(a1_fb),
        .pc_write(a1_pc), .ifid_write(a1_iw), .idex_bubble(a1_bub),
        .ifid_flush(a1_fl), .busy(a1_busy)
    );

    pipe_hazard_unit #(.REG_AW(5), .LOAD_LAT(3), .BR_IN_ID(1)) u3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
        .id_br_taken(id_br_taken), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_wr(ex_wr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_wr(mem_wr), .wb_wr(wb_wr), .mem_reg_write(mem_reg_write),
        .wb_reg_write(wb_reg_write), .fwd_a(a3_fa), .fwd_b(a3_fb),
        .pc_write(a3_pc), .ifid_write(a3_iw), .idex_bubble(a3_bub),
        .ifid_flush(a3_fl), .busy(a3_busy)
    );

    pipe_hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .BR_IN_ID(0)) un (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
        .id_br_taken(id_br_taken), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_wr(ex_wr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_wr(mem_wr), .wb_wr(wb_wr), .mem_reg_write(mem_reg_write),
        .wb_reg_write(wb_reg_write), .fwd_a(an_fa), .fwd_b(an_fb),
        .pc_write(an_pc), .ifid_write(an_iw), .idex_bubble(an_bub),
        .ifid_flush(an_fl), .busy(an_busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_is_branch = 1'b0;
        id_br_taken = 1'b0; ex_rs = '0; ex_rt = '0; ex_wr = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_wr = '0; wb_wr = '0;
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with conflicting inputs present: outputs must be forced.
        rst = 1'b0;
        clr();
        ex_rs = 5'd3; mem_wr = 5'd3; mem_reg_write = 1'b1; id_br_taken = 1'b1;
        nxt();
        @(negedge clk);
        chk("rst_pc", 16'(a1_pc), 16'd0);
        chk("rst_iw", 16'(a1_iw), 16'd0);
        chk("rst_bub", 16'(a1_bub), 16'd1);
        chk("rst_flush", 16'(a1_fl), 16'd0);
        chk("rst_busy", 16'(a3_busy), 16'd0);
        chk("rst_fwd_a", 16'(a1_fa), 16'd0);
        nxt();
        rst = 1'b1;
        clr();

        // Forwarding: MEM over WB, WB alone, register 0 never.
        ex_rs = 5'd3; ex_rt = 5'd3; mem_wr = 5'd3; mem_reg_write = 1'b1;
        wb_wr = 5'd3; wb_reg_write = 1'b1;
        @(negedge clk);
        chk("fwd_a_mem", 16'(a1_fa), 16'd2);
        chk("fwd_b_mem", 16'(a1_fb), 16'd2);
        chk("idle_pc", 16'(a1_pc), 16'd1);
        chk("idle_bub", 16'(a1_bub), 16'd0);
        nxt();
        mem_reg_write = 1'b0;
        @(negedge clk);
        chk("fwd_a_wb", 16'(a1_fa), 16'd1);
        nxt();
        ex_rs = 5'd0; mem_wr = 5'd0; mem_reg_write = 1'b1; wb_wr = 5'd0;
        ex_rt = 5'd7;
        @(negedge clk);
        chk("fwd_a_r0", 16'(a1_fa), 16'd0);
        chk("fwd_b_r0", 16'(a1_fb), 16'd0);
        nxt();
        clr();
        ex_rt = 5'd7; wb_wr = 5'd7; wb_reg_write = 1'b1; mem_wr = 5'd3; mem_reg_write = 1'b1;
        @(negedge clk);
        chk("fwd_b_wb", 16'(a1_fb), 16'd1);
        nxt();

        // Load-use: LW r5 in EX, ADD r5 in ID.
        clr();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_wr = 5'd5; id_rs = 5'd5;
        @(negedge clk);
        chk("lu1_pc", 16'(a1_pc), 16'd0);
        chk("lu1_iw", 16'(a1_iw), 16'd0);
        chk("lu1_bub", 16'(a1_bub), 16'd1);
        chk("lu1_busy", 16'(a1_busy), 16'd0);
        chk("lu3_c1_pc", 16'(a3_pc), 16'd0);
        chk("lu3_c1_busy", 16'(a3_busy), 16'd0);
        nxt();
        clr();
        ex_rs = 5'd5; mem_wr = 5'd5; mem_reg_write = 1'b1;
        @(negedge clk);
        chk("lu1_resume_pc", 16'(a1_pc), 16'd1);
        chk("lu1_resume_bub", 16'(a1_bub), 16'd0);
        chk("lu1_fwd_a", 16'(a1_fa), 16'd2);
        chk("lu3_c2_pc", 16'(a3_pc), 16'd0);
        chk("lu3_c2_busy", 16'(a3_busy), 16'd1);
        nxt();
        clr();
        @(negedge clk);
        chk("lu3_c3_busy", 16'(a3_busy), 16'd1);
        chk("lu3_c3_bub", 16'(a3_bub), 16'd1);
        nxt();
        @(negedge clk);
        chk("lu3_resume_pc", 16'(a3_pc), 16'd1);
        chk("lu3_resume_busy", 16'(a3_busy), 16'd0);
        nxt();

        // Taken BEQ r1,r4 in ID, ALU writing r4 in EX.
        id_is_branch = 1'b1; id_uses_rt = 1'b1; id_rs = 5'd1; id_rt = 5'd4;
        id_br_taken = 1'b1; ex_reg_write = 1'b1; ex_wr = 5'd4;
        @(negedge clk);
        chk("brex_pc", 16'(a1_pc), 16'd0);
        chk("brex_flush", 16'(a1_fl), 16'd0);
        chk("brex_busy", 16'(a1_busy), 16'd0);
        chk("nobr_pc", 16'(an_pc), 16'd1);
        chk("nobr_flush", 16'(an_fl), 16'd1);
        nxt();
        ex_reg_write = 1'b0; ex_wr = 5'd0; mem_wr = 5'd4; mem_reg_write = 1'b1;
        @(negedge clk);
        chk("brex_post_pc", 16'(a1_pc), 16'd1);
        chk("brex_post_flush", 16'(a1_fl), 16'd1);
        chk("brex3_post_flush", 16'(a3_fl), 16'd1);
        nxt();
        clr();
        @(negedge clk);
        chk("flush_pulse_end", 16'(a1_fl), 16'd0);
        nxt();

        // Taken BEQ r4 in ID, LW r4 in EX.
        id_is_branch = 1'b1; id_rs = 5'd4; id_br_taken = 1'b1;
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_wr = 5'd4;
        @(negedge clk);
        chk("brld_c1_pc", 16'(a1_pc), 16'd0);
        chk("brld_c1_flush", 16'(a1_fl), 16'd0);
        chk("brld_c1_busy", 16'(a1_busy), 16'd0);
        nxt();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_wr = 5'd0;
        mem_wr = 5'd4; mem_reg_write = 1'b1;
        @(negedge clk);
        chk("brld_c2_pc", 16'(a1_pc), 16'd0);
        chk("brld_c2_busy", 16'(a1_busy), 16'd1);
        chk("brld_c2_flush", 16'(a1_fl), 16'd0);
        nxt();
        mem_wr = 5'd0; mem_reg_write = 1'b0; wb_wr = 5'd4; wb_reg_write = 1'b1;
        @(negedge clk);
        chk("brld_post_pc", 16'(a1_pc), 16'd1);
        chk("brld_post_flush", 16'(a1_fl), 16'd1);
        chk("brld3_c3_busy", 16'(a3_busy), 16'd1);
        chk("brld3_c3_flush", 16'(a3_fl), 16'd0);
        nxt();
        clr();
        @(negedge clk);
        chk("brld_flush_end", 16'(a1_fl), 16'd0);
        nxt();
        nxt();

        // BEQ r6 in ID with the LW r6 one stage further on, in MEM.
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_wr = 5'd9;
        @(negedge clk);
        chk("ld_nohit_pc", 16'(a3_pc), 16'd1);
        nxt();
        clr();
        id_is_branch = 1'b1; id_rs = 5'd6; id_br_taken = 1'b1;
        mem_wr = 5'd6; mem_reg_write = 1'b1;
        @(negedge clk);
        chk("brmem1_pc", 16'(a1_pc), 16'd0);
        chk("brmem1_flush", 16'(a1_fl), 16'd0);
        chk("brmem3_pc", 16'(a3_pc), 16'd0);
        chk("nobr_mem_flush", 16'(an_fl), 16'd1);
        nxt();
        clr();
        @(negedge clk);
        chk("brmem1_resume", 16'(a1_pc), 16'd1);
        chk("brmem3_busy", 16'(a3_busy), 16'd1);
        for (int i = 0; i < 4; i++) nxt();

        // Reset during the second stall cycle of a LOAD_LAT=3 load-use stall.
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_wr = 5'd5; id_rs = 5'd5;
        @(negedge clk);
        chk("rs_c1_pc", 16'(a3_pc), 16'd0);
        nxt();
        clr();
        rst = 1'b0;
        @(negedge clk);
        chk("rs_in_busy", 16'(a3_busy), 16'd0);
        chk("rs_in_pc", 16'(a3_pc), 16'd0);
        chk("rs_in_bub", 16'(a3_bub), 16'd1);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk("rs_after_busy", 16'(a3_busy), 16'd0);
        chk("rs_after_pc", 16'(a3_pc), 16'd1);
        chk("rs_after_bub", 16'(a3_bub), 16'd0);
        nxt();
        @(negedge clk);
        chk("rs_after2_pc", 16'(a3_pc), 16'd1);
        chk("rs_after2_busy", 16'(a3_busy), 16'd0);
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It replaces the fixed load-use check with a stall state machine that supports multi-cycle data-memory latency and ID-stage branch operand hazards. It generates PC/IF-ID write enables, the ID/EX bubble, the IF-ID flush and per-operand EX forwarding selects. It sits beside the control decoder and drives the pipeline registers and the EX operand muxes.

## Interface
- `REG_AW`, default 5: register-address width.
- `LOAD_LAT`, default 1: stall cycles a load-use pair requires (1..7).
- `BR_IN_ID`, default 1: when 1, branches compare in ID and need operand hazard checks.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `id_rs`, `id_rt` in REG_AW: source registers of the instruction in ID.
- `id_uses_rt` in 1: the ID instruction reads rt (R-type, SW, BEQ, BNE).
- `id_is_branch` in 1: the ID instruction is BEQ or BNE.
- `id_br_taken` in 1: branch/jump resolved taken in ID.
- `ex_rs`, `ex_rt`, `ex_wr` in REG_AW: EX sources and EX destination.
- `ex_reg_write`, `ex_mem_read` in 1: EX writes the register file / EX is a load.
- `mem_wr`, `wb_wr` in REG_AW: MEM and WB destinations.
- `mem_reg_write`, `wb_reg_write` in 1: MEM and WB write enables.
- `fwd_a`, `fwd_b` out 2: EX operand select. 0 = register file, 1 = WB, 2 = MEM.
- `pc_write`, `ifid_write` out 1: hold the PC and IF/ID when 0.
- `idex_bubble` out 1: zero the ID/EX control fields.
- `ifid_flush` out 1: squash IF/ID.
- `busy` out 1: the FSM is not in RUN.

## Operation
- Forwarding is combinational, and MEM has priority over WB.
  - `fwd_a` = 2 if `mem_reg_write && mem_wr==ex_rs && ex_rs!=0`.
  - Otherwise `fwd_a` = 1 if the same condition holds for WB.
  - Otherwise `fwd_a` = 0.
  - `fwd_b` is computed the same way using `ex_rt`.
  - Register 0 is never forwarded.
- `hit(r)` = `r==id_rs || (id_uses_rt && r==id_rt)`, with `r!=0`.
- Load-use hazard: `ex_mem_read && hit(ex_wr)`.
- Branch hazard (only when `BR_IN_ID`, and only when `id_is_branch`):
  - EX hazard: `ex_reg_write && hit(ex_wr)`.
  - MEM-load hazard: `mem_reg_write` && the MEM instruction was a load && `hit(mem_wr)`. A load is tracked by one internal flag, registered from `ex_mem_read` when not in reset.
- FSM states: RUN, STALL.
  - RUN, hazard detected: set stall outputs this cycle. Load counter `cnt` with the required extra cycles:
    - Load-use: `LOAD_LAT-1`.
    - Branch on an EX ALU result: 0.
    - Branch on an EX load: `LOAD_LAT`.
    - Branch on a MEM load: `LOAD_LAT-1`.
  - RUN, hazard detected and `cnt` loaded nonzero: go to STALL.
  - STALL: hold the stall outputs. Decrement `cnt`. Return to RUN after the cycle in which `cnt==1`. In that RUN cycle the hazard check is re-evaluated.
- Stall outputs: `pc_write=0`, `ifid_write=0`, `idex_bubble=1`.
- Flush: `ifid_flush = id_br_taken` only in RUN with no hazard detected. A stall suppresses the flush, because the branch has not resolved yet.

## Timing
- Forwarding selects: zero latency.
- Stall outputs: asserted in the same cycle the hazard is detected. Total stall length = loaded `cnt` + 1 cycles.
- `ifid_flush`: one-cycle pulse in the taken cycle, with `pc_write=1`.
- While `rst==0`, at each clock:
  - State becomes RUN, `cnt` becomes 0 and the load flag is cleared.
  - Outputs are forced: `pc_write=0`, `ifid_write=0`, `idex_bubble=1`, `ifid_flush=0`, `busy=0`, `fwd_a=fwd_b=0`.
- Reset asserted mid-STALL aborts the stall immediately.
- Simultaneous MEM and WB match on the same register: MEM wins.
- `id_br_taken` arriving during STALL is ignored. The ID instruction is held and re-evaluated.

## Configuration
- `PIPE_HAZARD_PERF_EN` defined adds two outputs:
  - `stall_cnt`, 16 bits: increments every cycle `pc_write==0` outside reset.
  - `flush_cnt`, 16 bits: increments on each `ifid_flush`.
  - Both saturate at 16'hFFFF and clear on reset.
- `PIPE_HAZARD_PERF_EN` not defined: the ports and counters are absent, and the rest of the behaviour is identical.

## Structure
- Shared package `hazard_pkg`:
  - Forward-select constants `FWD_RF=0`, `FWD_WB=1`, `FWD_MEM=2`.
  - FSM state encoding `HZ_RUN`, `HZ_STALL`.
  - Counter width `HZ_CNT_W=3`.
- One sub-module, `fwd_sel`. It holds the per-operand priority comparator (src, mem_wr/we, wb_wr/we → 2-bit select) and is instantiated twice, for A and B.

## Test plan
- EX `ex_rs=3`, MEM writes r3, WB writes r3 → `fwd_a=2`. With the MEM write disabled → `fwd_a=1`. With `ex_rs=0` and MEM writing r0 → `fwd_a=0`.
- `LOAD_LAT=1`: LW r5 in EX, ADD using r5 in ID → exactly 1 cycle with `pc_write=0` and `idex_bubble=1`. The next cycle gives `fwd_a=2`.
- `LOAD_LAT=3`: same pair → 3 stall cycles. `busy=1` for cycles 2–3, then resume.
- BEQ r4 in ID, ADD writing r4 in EX → 1 stall cycle. With LW r4 in EX and `LOAD_LAT=1` → 2 stall cycles. No `ifid_flush` during the stall.
- Taken BEQ, no hazard → `ifid_flush=1` for one cycle. Taken BEQ with a hazard → flush only in the first post-stall cycle.
- `rst` pulled low in the 2nd stall cycle with `LOAD_LAT=3` → next cycle state is RUN and `cnt=0`. After release, no residual stall.
